gain_ramp_stage: RTL and testbench

- Registered, multi-channel successor to the combinational gain block.
- Scales N_CH signed fixed-point Q(P.F) samples by a programmable unsigned gain UQ(GP.GF).
- Gain changes are ramped to avoid zipper noise; results are rounded and saturated, with per-channel saturation flags.
- Sits between the filter output (yk) and the DAC/output formatter, on the sample-strobe pipeline.

---
 rtl/gain_pkg.sv | 26 ++
 rtl/gain_round_sat.sv | 35 +++
 rtl/gain_ramp_stage.sv | 113 +++++++++++
 tb/tb_gain_ramp_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gain_pkg.sv
// Shared constants and types for the ramped multi-channel gain stage.
// Sample format Q(P.F) signed, gain format UQ(GP.GF).
package gain_pkg;

    localparam int P      = 4;
    localparam int F      = 13;
    localparam int WIDTH  = 1 + P + F;
    localparam int GP     = 2;
    localparam int GF     = 4;
    localparam int GW     = GP + GF;
    localparam int N_CH   = 2;
    localparam int STEP   = 1;

    localparam int UNITY   = 1 << GF;
    localparam int PROD_W  = WIDTH + GW + 1;
    localparam int ROUND_K = 1 << (GF - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

endpackage

// File: rtl/gain_round_sat.sv
// One channel of the output stage: round half up, drop GF fraction bits,
// clamp to the sample range and flag the clamp.
module gain_round_sat
    import gain_pkg::*;
(
    input  logic signed [PROD_W-1:0] prod,
    output logic        [WIDTH-1:0]  y,
    output logic                     sat
);

    localparam int SUM_W = PROD_W + 1;
    localparam int SH_W  = SUM_W - GF;

    localparam logic signed [SH_W-1:0] HI = SAT_MAX;
    localparam logic signed [SH_W-1:0] LO = SAT_MIN;

    logic signed [SUM_W-1:0] sum;
    logic signed [SH_W-1:0]  sh;

    always_comb begin
        sum = {prod[PROD_W-1], prod} + SUM_W'(ROUND_K);
        // Slicing off the low bits of a signed value is the arithmetic shift.
        sh  = sum[SUM_W-1:GF];
        y   = sh[WIDTH-1:0];
        sat = 1'b0;
        if (sh > HI) begin
            y   = SAT_MAX;
            sat = 1'b1;
        end else if (sh < LO) begin
            y   = SAT_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/gain_ramp_stage.sv
// Two-stage registered gain with sample-paced gain ramping,
// rounding and per-channel saturation.
module gain_ramp_stage
    import gain_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*WIDTH-1:0]  yk,
    input  logic                   in_valid,
    input  logic [GW-1:0]          gain_target,
    input  logic                   gain_load,
    output logic [N_CH*WIDTH-1:0]  ykgain,
    output logic                   out_valid,
    output logic [N_CH-1:0]        sat,
    output logic [GW-1:0]          gain_cur,
    output logic                   ramp_busy
);

    state_t state, state_n;

    logic [GW-1:0] target;
    logic [GW-1:0] tgt_eff;
    logic [GW-1:0] gain_step;
    logic [GW-1:0] gain_nxt;

    logic signed [PROD_W-1:0] prod_d [N_CH];
    logic signed [PROD_W-1:0] prod_q [N_CH];
    logic                     v1;

    logic [N_CH*WIDTH-1:0] y_rs;
    logic [N_CH-1:0]       sat_rs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ramp_busy <= 1'b0;
            gain_cur  <= GW'(UNITY);
            target    <= GW'(UNITY);
        end else begin
            state     <= state_n;
            ramp_busy <= (state_n == RAMP);
            gain_cur  <= gain_nxt;
            if (gain_load)
                target <= gain_target;
        end
    end

    // A load in the same cycle as a sample steps toward the new target.
    always_comb begin
        tgt_eff   = gain_load ? gain_target : target;
        gain_step = gain_cur;
        unique case (1'b1)
            (tgt_eff > gain_cur):
                gain_step = (tgt_eff - gain_cur > GW'(STEP))
                          ? gain_cur + GW'(STEP) : tgt_eff;
            (tgt_eff < gain_cur):
                gain_step = (gain_cur - tgt_eff > GW'(STEP))
                          ? gain_cur - GW'(STEP) : tgt_eff;
            (tgt_eff == gain_cur):
                gain_step = gain_cur;
        endcase
        gain_nxt = in_valid ? gain_step : gain_cur;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (gain_load)
                    state_n = (gain_nxt != tgt_eff) ? RAMP : IDLE;
            RAMP:
                state_n = (gain_nxt != tgt_eff) ? RAMP : IDLE;
        endcase
    end

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            prod_d[c] = PROD_W'($signed(yk[c*WIDTH +: WIDTH]))
                      * PROD_W'($signed({1'b0, gain_cur}));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            ykgain    <= '0;
            sat       <= '0;
            for (int c = 0; c < N_CH; c++)
                prod_q[c] <= '0;
        end else begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                for (int c = 0; c < N_CH; c++)
                    prod_q[c] <= prod_d[c];
            end
            if (v1) begin
                ykgain <= y_rs;
                sat    <= sat_rs;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        gain_round_sat u_rs (
            .prod (prod_q[c]),
            .y    (y_rs[c*WIDTH +: WIDTH]),
            .sat  (sat_rs[c])
        );
    end

endmodule

// File: tb/tb_gain_ramp_stage.sv
// Directed bench for gain_ramp_stage: unity, ramp, saturation,
// rounding, retarget mid-ramp and reset with samples in flight.
module tb_gain_ramp_stage;
    import gain_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [35:0] yk = '0;
    logic        in_valid = 1'b0;
    logic [5:0]  gain_target = 6'd16;
    logic        gain_load = 1'b0;
    logic [35:0] ykgain;
    logic        out_valid;
    logic [1:0]  sat;
    logic [5:0]  gain_cur;
    logic        ramp_busy;

    int vecs = 0;
    int errs = 0;

    gain_ramp_stage dut (
        .clk         (clk),
        .rst         (rst),
        .yk          (yk),
        .in_valid    (in_valid),
        .gain_target (gain_target),
        .gain_load   (gain_load),
        .ykgain      (ykgain),
        .out_valid   (out_valid),
        .sat         (sat),
        .gain_cur    (gain_cur),
        .ramp_busy   (ramp_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input logic v);
        yk       = {18'(b), 18'(a)};
        in_valid = v;
    endtask

    function automatic int ch(input int i);
        logic signed [17:0] t;
        t = ykgain[i*18 +: 18];
        return int'(t);
    endfunction

    task automatic send(input int a, input int b, output logic ov,
                        output int y0, output int y1, output logic [1:0] s);
        drive(a, b, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        ov = out_valid;
        y0 = ch(0);
        y1 = ch(1);
        s  = sat;
    endtask

    task automatic load(input int g);
        gain_target = 6'(g);
        gain_load   = 1'b1;
        tick();
        gain_load   = 1'b0;
    endtask

    task automatic set_gain(input int g);
        load(g);
        for (int i = 0; i < 100 && gain_cur != 6'(g); i++) begin
            drive(0, 0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        gain_load = 1'b0;
        yk        = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        vecs++;
        if (ykgain !== 36'd0) begin
            errs++; $display("FAIL reset_ykgain: got %h want 0", ykgain);
        end
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        vecs++;
        if (sat !== 2'b00) begin
            errs++; $display("FAIL reset_sat: got %b want 00", sat);
        end
        vecs++;
        if (gain_cur !== 6'd16) begin
            errs++; $display("FAIL reset_gain: got %0d want 16", gain_cur);
        end
        vecs++;
        if (ramp_busy !== 1'b0) begin
            errs++; $display("FAIL reset_busy: got %b want 0", ramp_busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unity();
        logic ov; int y0, y1; logic [1:0] s;
        send(8192, -8192, ov, y0, y1, s);
        vecs++;
        if (ov !== 1'b1) begin
            errs++; $display("FAIL unity_valid: got %b want 1", ov);
        end
        vecs++;
        if (y0 != 8192 || y1 != -8192 || s !== 2'b00) begin
            errs++;
            $display("FAIL unity_data: got %0d %0d sat %b want 8192 -8192 sat 00",
                     y0, y1, s);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0 || ch(0) != 8192) begin
            errs++;
            $display("FAIL unity_hold: got valid %b y0 %0d want 0 8192",
                     out_valid, ch(0));
        end
    endtask

    task automatic test_ramp();
        int g;
        do_reset();
        load(32);
        vecs++;
        if (ramp_busy !== 1'b1 || gain_cur !== 6'd16) begin
            errs++;
            $display("FAIL ramp_start: got busy %b gain %0d want 1 16",
                     ramp_busy, gain_cur);
        end
        for (int i = 0; i < 20; i++) begin
            drive(8192, -8192, 1'b1);
            tick();
            g = (17 + i < 32) ? 17 + i : 32;
            vecs++;
            if (gain_cur !== 6'(g) || ramp_busy !== 1'((17 + i) < 32)) begin
                errs++;
                $display("FAIL ramp_gain[%0d]: got %0d busy %b want %0d busy %b",
                         i, gain_cur, ramp_busy, g, (17 + i) < 32);
            end
            if (i >= 1) begin
                g = (15 + i < 32) ? 15 + i : 32;
                vecs++;
                if (out_valid !== 1'b1 || ch(0) != 512 * g || ch(1) != -512 * g) begin
                    errs++;
                    $display("FAIL ramp_out[%0d]: got v%b %0d %0d want %0d %0d",
                             i, out_valid, ch(0), ch(1), 512 * g, -512 * g);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        vecs++;
        if (out_valid !== 1'b1 || ch(0) != 16384) begin
            errs++;
            $display("FAIL ramp_last: got v%b %0d want 16384", out_valid, ch(0));
        end
        tick();
        vecs++;
        if (out_valid !== 1'b0) begin
            errs++; $display("FAIL ramp_drain: got %b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic ov; int y0, y1; logic [1:0] s;
        set_gain(63);
        vecs++;
        if (gain_cur !== 6'd63) begin
            errs++; $display("FAIL sat_gain: got %0d want 63", gain_cur);
        end
        send(98304, -131072, ov, y0, y1, s);
        vecs++;
        if (ov !== 1'b1 || y0 != 131071 || y1 != -131072 || s !== 2'b11) begin
            errs++;
            $display("FAIL sat_data: got v%b %0d %0d sat %b want 131071 -131072 11",
                     ov, y0, y1, s);
        end
    endtask

    task automatic test_gain_zero();
        logic ov; int y0, y1; logic [1:0] s;
        set_gain(0);
        send(131071, -131072, ov, y0, y1, s);
        vecs++;
        if (ov !== 1'b1 || y0 != 0 || y1 != 0 || s !== 2'b00) begin
            errs++;
            $display("FAIL zero_gain: got v%b %0d %0d sat %b want 0 0 00",
                     ov, y0, y1, s);
        end
    endtask

    task automatic test_rounding();
        logic ov; int y0, y1; logic [1:0] s;
        set_gain(8);
        send(1, -1, ov, y0, y1, s);
        vecs++;
        if (y0 != 1 || y1 != 0 || s !== 2'b00) begin
            errs++;
            $display("FAIL round_g8: got %0d %0d sat %b want 1 0 00", y0, y1, s);
        end
        send(-3, 3, ov, y0, y1, s);
        vecs++;
        if (y0 != -1 || y1 != 2) begin
            errs++; $display("FAIL round_g8b: got %0d %0d want -1 2", y0, y1);
        end
        set_gain(4);
        send(1, -1, ov, y0, y1, s);
        vecs++;
        if (y0 != 0 || y1 != 0) begin
            errs++; $display("FAIL round_g4: got %0d %0d want 0 0", y0, y1);
        end
    endtask

    task automatic test_midramp();
        int exp_g[6]  = '{23, 22, 21, 20, 20, 20};
        logic exp_b[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        load(32);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        vecs++;
        if (gain_cur !== 6'd24) begin
            errs++; $display("FAIL mid_gain: got %0d want 24", gain_cur);
        end
        load(20);
        vecs++;
        if (gain_cur !== 6'd24 || ramp_busy !== 1'b1) begin
            errs++;
            $display("FAIL mid_reload: got %0d busy %b want 24 1", gain_cur, ramp_busy);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 1'b1);
            tick();
            vecs++;
            if (gain_cur !== 6'(exp_g[i]) || ramp_busy !== exp_b[i]) begin
                errs++;
                $display("FAIL mid_down[%0d]: got %0d busy %b want %0d busy %b",
                         i, gain_cur, ramp_busy, exp_g[i], exp_b[i]);
            end
        end
        drive(8192, 0, 1'b1);
        gain_target = 6'd22;
        gain_load   = 1'b1;
        tick();
        gain_load = 1'b0;
        in_valid  = 1'b0;
        vecs++;
        if (gain_cur !== 6'd21 || ramp_busy !== 1'b1) begin
            errs++;
            $display("FAIL load_with_sample: got %0d busy %b want 21 1",
                     gain_cur, ramp_busy);
        end
        tick();
        vecs++;
        if (out_valid !== 1'b1 || ch(0) != 10240) begin
            errs++;
            $display("FAIL load_sample_out: got v%b %0d want 10240", out_valid, ch(0));
        end
    endtask

    task automatic test_reset_in_flight();
        logic ov; int y0, y1; logic [1:0] s;
        bit seen;
        do_reset();
        send(8192, -8192, ov, y0, y1, s);
        load(32);
        drive(8192, 8192, 1'b1);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        vecs++;
        if (ykgain !== 36'd0 || out_valid !== 1'b0 || sat !== 2'b00) begin
            errs++;
            $display("FAIL rif_outputs: got %h v%b sat %b want 0 0 00",
                     ykgain, out_valid, sat);
        end
        vecs++;
        if (gain_cur !== 6'd16 || ramp_busy !== 1'b0) begin
            errs++;
            $display("FAIL rif_gain: got %0d busy %b want 16 0", gain_cur, ramp_busy);
        end
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        vecs++;
        if (seen) begin
            errs++; $display("FAIL rif_discard: got out_valid 1 want 0");
        end
        send(4096, -4096, ov, y0, y1, s);
        vecs++;
        if (ov !== 1'b1 || y0 != 4096 || y1 != -4096) begin
            errs++;
            $display("FAIL rif_resume: got v%b %0d %0d want 4096 -4096", ov, y0, y1);
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_ramp();
        test_saturation();
        test_gain_zero();
        test_rounding();
        test_midramp();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
